uart_core: RTL and testbench

//  Full-duplex 8N1 UART (8 data bits, no parity, 1 stop bit), LSB first, 16x oversampled receiver.

---
 rtl/uart_core_if.sv | 12 +
 rtl/uart_core.sv | 155 +++++++++++++++
 tb/tb_uart_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
// uart_core_if: byte-wide parallel handshake between the UART core and its host
interface uart_core_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    modport master (input rx_data, rx_avail, rx_error, tx_busy, output rx_ack, tx_data, tx_wr);
    modport slave (output rx_data, rx_avail, rx_error, tx_busy, input rx_ack, tx_data, tx_wr);
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART, LSB first, 16x oversampled receiver, byte handshake
module uart_core #(
    parameter int freq_hz = 100_000_000,
    parameter int baud    = 115_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rxd,
    output logic        uart_txd,
    uart_core_if.slave  bus
);
    localparam int DIV_RAW = freq_hz / (baud * 16);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int CW      = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [CW-1:0] div_cnt;
    logic          tick;

    assign tick = div_cnt == CW'(DIV - 1);

    // free-running oversample tick shared by TX and RX so loopback stays bit-aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end

    state_t     tx_state;
    logic [3:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;

    // transmitter: each bit lasts 16 ticks, 4-bit tick counter wraps at the bit boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state    <= IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_sh       <= '0;
            uart_txd    <= 1'b1;
            bus.tx_busy <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: if (bus.tx_wr && !bus.tx_busy) begin
                    tx_sh       <= bus.tx_data;
                    bus.tx_busy <= 1'b1;
                    uart_txd    <= 1'b0;
                    tx_cnt      <= '0;
                    tx_state    <= START;
                end
                START: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == 4'd15) begin
                        uart_txd <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_bit   <= '0;
                        tx_state <= DATA;
                    end
                end
                DATA: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == 4'd15) begin
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            uart_txd <= tx_sh[0];
                            tx_sh    <= tx_sh >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                end
                STOP: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == 4'd15) begin
                        bus.tx_busy <= 1'b0;
                        tx_state    <= IDLE;
                    end
                end
            endcase
        end
    end

    logic [1:0] rx_sync;
    logic       rxs;

    assign rxs = rx_sync[1];

    // two-flop synchronizer for the asynchronous serial input, idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], uart_rxd};
    end

    state_t     rx_state;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh;

    // receiver: align to mid start bit, then sample every 16 ticks; completion overrides ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            bus.rx_data  <= '0;
            bus.rx_avail <= 1'b0;
            bus.rx_error <= 1'b0;
        end else begin
            if (bus.rx_ack) begin
                bus.rx_avail <= 1'b0;
                bus.rx_error <= 1'b0;
            end
            if (tick) begin
                case (rx_state)
                    IDLE: if (!rxs) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                    START: begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd7) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rxs ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd15) begin
                            rx_sh  <= {rxs, rx_sh[7:1]};
                            rx_bit <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) rx_state <= STOP;
                        end
                    end
                    STOP: begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd15) begin
                            rx_state <= IDLE;
                            if (rxs) begin
                                bus.rx_data  <= rx_sh;
                                bus.rx_avail <= 1'b1;
                                bus.rx_error <= 1'b0;
                            end else begin
                                bus.rx_error <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core with DIV=2 (32 clk per bit)
module tb_uart_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loop = 1'b0;
    logic rxd_drv = 1'b1;
    logic txd;
    logic rxd;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_core_if bus();

    assign rxd = loop ? txd : rxd_drv;

    uart_core #(.freq_hz(50_000_000), .baud(1_152_000)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (rxd),
        .uart_txd (txd),
        .bus      (bus)
    );

    // 100 MHz-style clock, period 10
    always #5 clk = ~clk;

    // cycle counter for measuring busy duration
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_wr = 1'b1;
        @(negedge clk);
        bus.tx_wr = 1'b0;
    endtask

    task automatic pulse_ack;
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd_drv = 1'b0;
        tick_n(32);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            tick_n(32);
        end
        rxd_drv = stop;
        tick_n(stop ? 32 : 24);
        rxd_drv = 1'b1;
        tick_n(8);
    endtask

    task automatic capture_tx(output logic [7:0] b, output logic ok);
        int w = 0;
        b = '0;
        ok = 1'b0;
        while (txd !== 1'b0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (txd !== 1'b0) return;
        tick_n(16);
        if (txd !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            tick_n(32);
            b[i] = txd;
        end
        tick_n(32);
        ok = (txd === 1'b1);
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (bus.tx_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // directed scenario sequence
    initial begin
        logic [7:0] b;
        logic       ok;
        int         n;
        int         acc;
        int         falls;
        bus.rx_ack = 1'b0;
        bus.tx_wr = 1'b0;
        bus.tx_data = 8'h00;
        tick_n(4);
        check("rst_txd", txd, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_avail", bus.rx_avail, 0);
        check("rst_error", bus.rx_error, 0);
        check("rst_data", bus.rx_data, 8'h00);
        reset = 1'b1;
        tick_n(50);
        check("idle_txd", txd, 1);
        check("idle_avail", bus.rx_avail, 0);

        write_tx(8'h41);
        acc = cyc;
        check("tx41_busy_set", bus.tx_busy, 1);
        capture_tx(b, ok);
        check("tx41_data", b, 8'h41);
        check("tx41_frame", ok, 1);
        check("tx41_busy_mid", bus.tx_busy, 1);
        wait_busy_low(n);
        check("tx41_busy_len", (cyc - acc >= 318 && cyc - acc <= 321), 1);

        loop = 1'b1;
        write_tx(8'h55);
        wait_busy_low(n);
        check("lb55_done", n < 2000, 1);
        tick_n(4);
        check("lb55_avail", bus.rx_avail, 1);
        check("lb55_data", bus.rx_data, 8'h55);
        check("lb55_error", bus.rx_error, 0);
        pulse_ack;
        check("lb55_ack", bus.rx_avail, 0);
        write_tx(8'hA5);
        wait_busy_low(n);
        check("lba5_done", n < 2000, 1);
        tick_n(4);
        check("lba5_avail", bus.rx_avail, 1);
        check("lba5_data", bus.rx_data, 8'hA5);
        check("lba5_error", bus.rx_error, 0);
        pulse_ack;
        check("lba5_ack", bus.rx_avail, 0);
        loop = 1'b0;
        tick_n(20);

        send_frame(8'hF0, 1'b0);
        tick_n(4);
        check("ferr_error", bus.rx_error, 1);
        check("ferr_avail", bus.rx_avail, 0);
        pulse_ack;
        check("ferr_ack", bus.rx_error, 0);
        send_frame(8'h3C, 1'b1);
        check("rx3c_avail", bus.rx_avail, 1);
        check("rx3c_data", bus.rx_data, 8'h3C);
        check("rx3c_error", bus.rx_error, 0);
        pulse_ack;

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_avail", bus.rx_avail, 1);
        check("ovr_data", bus.rx_data, 8'h22);
        pulse_ack;
        check("ovr_ack", bus.rx_avail, 0);

        write_tx(8'h5A);
        fork
            capture_tx(b, ok);
            begin
                tick_n(100);
                write_tx(8'hFF);
            end
        join
        check("drop_data", b, 8'h5A);
        check("drop_frame", ok, 1);
        wait_busy_low(n);
        check("drop_busy_low", bus.tx_busy, 0);
        falls = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd === 1'b0) falls++;
        end
        check("drop_no_second", falls, 0);

        write_tx(8'h00);
        rxd_drv = 1'b0;
        tick_n(32);
        rxd_drv = 1'b0;
        tick_n(32);
        rxd_drv = 1'b1;
        tick_n(32);
        rxd_drv = 1'b1;
        tick_n(32);
        rxd_drv = 1'b1;
        tick_n(16);
        check("mid_txd_low", txd, 0);
        check("mid_busy", bus.tx_busy, 1);
        reset = 1'b0;
        #1;
        check("arst_txd", txd, 1);
        check("arst_busy", bus.tx_busy, 0);
        check("arst_avail", bus.rx_avail, 0);
        rxd_drv = 1'b1;
        tick_n(4);
        reset = 1'b1;
        tick_n(400);
        check("post_rst_avail", bus.rx_avail, 0);
        check("post_rst_error", bus.rx_error, 0);
        check("post_rst_txd", txd, 1);
        send_frame(8'h7E, 1'b1);
        check("rx7e_avail", bus.rx_avail, 1);
        check("rx7e_data", bus.rx_data, 8'h7E);
        check("rx7e_error", bus.rx_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
